mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the CPU's single `memory_control` instance. It lets the instruction-fetch path and the load/store data path share that one memory controller. It picks one requester round-robin, latches that request, and drives the `start`/`active`/`done` handshake of `memory_control`. It then returns the read data and a one-cycle completion pulse to the winning requester. A watchdog aborts transactions the memory never completes.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one memory_control between fetch (f) and data (d).
// Latency: req seen in IDLE -> start/gnt next cycle; mem_done -> *_done next cycle, IDLE the cycle after.
// Backpressure: requesters hold *_req until *_done; losers wait in IDLE, one idle bus cycle between transactions.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   f_*/d_* req,addr,mode,we,wdata   requester inputs; f_gnt/d_gnt, f_done/d_done pulses out
//   rdata                            read data of the last completed transaction (0 after a timeout)
//   mem_*                            handshake and latched request towards memory_control
//   busy, owner, timeout_err         status; timeout_err is sticky until reset
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic [2:0]  f_mode,
  input  logic        f_we,
  input  logic [31:0] f_wdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_mode,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        f_gnt,
  output logic        d_gnt,
  output logic        f_done,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        mem_start,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_mode,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_done,
  input  logic        mem_active,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // A zero TIMEOUT_CYCLES still gets a 1-bit counter so nothing has zero width.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, next_state;
  logic             last_owner;
  logic [CNT_W-1:0] wd_cnt;
  logic             we_q;
  logic             any_req;
  logic             pick_d;
  logic             timeout_hit;

  // memory_control's busy flag is informational only; the handshake is start/done.
  logic unused_mem_active;
  assign unused_mem_active = mem_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    any_req     = f_req | d_req;
    // On a tie the side that did not own the previous transaction wins.
    pick_d      = d_req & (~f_req | ~last_owner);
    // mem_done in the same cycle takes priority over the watchdog.
    timeout_hit = (TIMEOUT_CYCLES > 0) && (state == WAIT) && !mem_done && (wd_cnt == CNT_LAST);
    next_state  = state;
    case (state)
      IDLE:  if (any_req) next_state = ISSUE;
      ISSUE: next_state = mem_done ? RESP : WAIT;
      WAIT:  if (mem_done || timeout_hit) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner          <= 1'b0;
      last_owner     <= 1'b1;   // data "owned" last, so fetch wins the first tie
      mem_address    <= '0;
      mem_mode       <= '0;
      mem_write_data <= '0;
      we_q           <= 1'b0;
      rdata          <= '0;
      timeout_err    <= 1'b0;
      wd_cnt         <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner          <= pick_d;
        mem_address    <= pick_d ? d_addr  : f_addr;
        mem_mode       <= pick_d ? d_mode  : f_mode;
        mem_write_data <= pick_d ? d_wdata : f_wdata;
        we_q           <= pick_d ? d_we    : f_we;
      end

      if (state == ISSUE)
        wd_cnt <= '0;
      else if (state == WAIT && wd_cnt != CNT_MAX)
        wd_cnt <= wd_cnt + CNT_ONE;

      if ((state == ISSUE || state == WAIT) && mem_done) begin
        rdata <= mem_read_data;
      end else if (timeout_hit) begin
        rdata       <= '0;
        timeout_err <= 1'b1;
      end

      if (state == RESP) last_owner <= owner;
    end
  end

  // Handshake outputs decode straight from the state register, so reset clears them at once.
  assign mem_start        = (state == ISSUE);
  assign f_gnt            = mem_start & ~owner;
  assign d_gnt            = mem_start &  owner;
  assign f_done           = (state == RESP) & ~owner;
  assign d_done           = (state == RESP) &  owner;
  assign busy             = (state != IDLE);
  assign mem_write_enable = we_q & ((state == ISSUE) | (state == WAIT));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, f_we, d_we;
  logic [31:0] f_addr, d_addr, f_wdata, d_wdata;
  logic [2:0]  f_mode, d_mode;
  logic        f_gnt, d_gnt, f_done, d_done;
  logic [31:0] rdata;
  logic        mem_start, mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_mode;
  logic        mem_done, mem_active;
  logic        busy, owner, timeout_err;

  int checks   = 0;
  int failures = 0;

  // Memory model controls: latency from mem_start (0 = done during ISSUE, <0 = never).
  int          mem_lat = -1;
  logic [31:0] mem_val = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_mode(f_mode), .f_we(f_we), .f_wdata(f_wdata),
    .d_req(d_req), .d_addr(d_addr), .d_mode(d_mode), .d_we(d_we), .d_wdata(d_wdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .f_done(f_done), .d_done(d_done), .rdata(rdata),
    .mem_start(mem_start), .mem_address(mem_address), .mem_mode(mem_mode),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_done(mem_done), .mem_active(mem_active),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  assign mem_active = busy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: sees mem_start in ISSUE, answers mem_lat cycles later for one cycle.
  initial begin
    mem_done      = 1'b0;
    mem_read_data = '0;
    forever begin
      step();
      if (mem_start && mem_lat >= 0) begin
        if (mem_lat > 0) repeat (mem_lat) step();
        mem_done      = 1'b1;
        mem_read_data = mem_val;
        step();
        mem_done      = 1'b0;
      end
    end
  end

  typedef struct {
    logic        f_req;
    logic        d_req;
    logic [31:0] f_addr;
    logic [31:0] d_addr;
    logic [2:0]  d_mode;
    logic        d_we;
    logic [31:0] d_wdata;
    int          lat;
    logic [31:0] rval;
    logic        exp_owner;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_terr;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int   n;
    bit   got;
    bit   we_ok;
    logic exp_we;
    int   exp_steps;
    f_req   = v.f_req;   d_req   = v.d_req;
    f_addr  = v.f_addr;  d_addr  = v.d_addr;
    d_mode  = v.d_mode;  d_we    = v.d_we;   d_wdata = v.d_wdata;
    mem_lat = v.lat;     mem_val = v.rval;
    exp_we    = v.exp_owner ? v.d_we : 1'b0;
    exp_steps = (v.lat >= 0) ? v.lat + 1 : 5;   // 4 WAIT cycles then RESP on timeout

    n = 0; got = 0;
    while (!got && n < 20) begin
      step(); n++;
      if (f_gnt || d_gnt) got = 1;
    end
    chk("gnt_seen", got, 1);
    chk("gnt_latency", n, 1);
    chk("d_gnt", d_gnt, v.exp_owner);
    chk("f_gnt", f_gnt, !v.exp_owner);
    chk("mem_start", mem_start, 1);
    chk("owner", owner, v.exp_owner);
    chk("mem_address", mem_address, v.exp_addr);
    chk("mem_mode", mem_mode, v.exp_owner ? v.d_mode : 3'b010);
    chk("mem_we_issue", mem_write_enable, exp_we);
    if (exp_we) chk("mem_write_data", mem_write_data, v.d_wdata);

    n = 0; got = 0; we_ok = 1;
    while (!got && n < 20) begin
      step(); n++;
      if (f_done || d_done) got = 1;
      else if (mem_write_enable !== exp_we) we_ok = 0;
    end
    chk("done_seen", got, 1);
    chk("done_latency", n, exp_steps);
    chk("mem_we_wait", we_ok, 1);
    chk("d_done", d_done, v.exp_owner);
    chk("f_done", f_done, !v.exp_owner);
    chk("rdata", rdata, v.exp_rdata);
    chk("timeout_err", timeout_err, v.exp_terr);
    chk("mem_we_resp", mem_write_enable, 0);

    f_req = 0; d_req = 0;
    step();
    chk("idle_after", {busy, f_done, d_done}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int   n;
    int   starts;
    bit   got;
    logic exp_o;

    // f_req d_req f_addr d_addr d_mode d_we d_wdata lat rval | owner addr rdata terr
    vecs[0] = '{1, 0, 32'h100, 32'h0,    3'b010, 0, 32'h0,        3, 32'hDEADBEEF, 0, 32'h100,  32'hDEADBEEF, 0};
    vecs[1] = '{1, 1, 32'h200, 32'h300,  3'b000, 0, 32'h0,        0, 32'h000000A5, 1, 32'h300,  32'h000000A5, 0};
    vecs[2] = '{1, 1, 32'h204, 32'h304,  3'b001, 0, 32'h0,        1, 32'hCAFEF00D, 0, 32'h204,  32'hCAFEF00D, 0};
    vecs[3] = '{0, 1, 32'h0,   32'h2004, 3'b010, 1, 32'h12345678, 2, 32'h55555555, 1, 32'h2004, 32'h55555555, 0};
    vecs[4] = '{0, 1, 32'h0,   32'h400,  3'b010, 0, 32'h0,       -1, 32'hFFFFFFFF, 1, 32'h400,  32'h0,        1};
    vecs[5] = '{1, 1, 32'h500, 32'h600,  3'b010, 0, 32'h0,        2, 32'h0BADF00D, 0, 32'h500,  32'h0BADF00D, 1};
    vecs[6] = '{0, 1, 32'h0,   32'h700,  3'b100, 0, 32'h0,        0, 32'h89ABCDEF, 1, 32'h700,  32'h89ABCDEF, 1};

    rst = 1;
    f_req = 0; d_req = 0; f_we = 0; d_we = 0;
    f_addr = 0; d_addr = 0; f_wdata = 0; d_wdata = 0;
    f_mode = 3'b010; d_mode = 0;
    #1;
    chk("reset_outputs", {f_gnt, d_gnt, f_done, d_done, mem_start, mem_write_enable, busy, owner, timeout_err}, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_addr", mem_address, 0);
    step(); step();
    rst = 0;
    step();

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset in the middle of WAIT: everything clears at once, no done pulse.
    d_req = 1; d_addr = 32'h800; d_we = 1; d_wdata = 32'hA5A5A5A5; mem_lat = -1;
    n = 0; got = 0;
    while (!got && n < 20) begin step(); n++; if (d_gnt) got = 1; end
    chk("midwait_gnt", got, 1);
    step(); step();
    chk("midwait_busy", busy, 1);
    rst = 1;
    #1;
    chk("midwait_rst_ctl", {f_gnt, d_gnt, f_done, d_done, mem_start, mem_write_enable, busy, owner, timeout_err}, 0);
    chk("midwait_rst_data", {rdata, mem_address, mem_write_data, 29'b0, mem_mode}, 0);
    d_req = 0; d_we = 0;
    repeat (2) begin step(); chk("midwait_no_done", {f_done, d_done}, 0); end
    rst = 0;

    // Tie right after reset and sustained contention: fetch first, then strict alternation.
    f_addr = 32'hF000; d_addr = 32'hD000; d_mode = 3'b010;
    mem_lat = 1; mem_val = 32'h77;
    f_req = 1; d_req = 1;
    for (int t = 0; t < 6; t++) begin
      exp_o = t[0];
      starts = 0; n = 0; got = 0;
      while (!got && n < 30) begin
        step(); n++;
        if (mem_start) begin
          starts++;
          chk("contend_owner", owner, exp_o);
          chk("contend_addr", mem_address, exp_o ? 32'hD000 : 32'hF000);
        end
        if (f_done || d_done) got = 1;
      end
      chk("contend_done", got, 1);
      chk("contend_starts", starts, 1);
      chk("contend_done_side", d_done, exp_o);
    end
    f_req = 0; d_req = 0;
    step(); step();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
